// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencing-controller FSM states and the
// architectural zero-register index.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch squashes,
// data-memory freezes with timeout, plus saturating stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             uses_rs2_IF_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             Mem_Read_ID_EX,
  input  logic             Reg_Write_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int                 WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = dmem_req & ~dmem_ready;

  assign load_use = Mem_Read_ID_EX & Reg_Write_ID_EX & (rd_ID_EX != REG_ZERO) &
                    ((rd_ID_EX == rs1_IF_ID) |
                     (uses_rs2_IF_ID & (rd_ID_EX == rs2_IF_ID)));

  // Priority decode: ERROR > mem_stall > branch > load_use > normal.
  // Gated by rst_n so every control reads 0 while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if (rst_n && state != ERROR && !mem_stall) begin
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (branch_taken_EX) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  // NOTE: asynchronous active-low reset; all sequential state uses <= so
  // every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!pc_en && state != ERROR && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);

      case (state)
        RUN: begin
          if (mem_stall) begin
            wait_cnt <= WAIT_W'(1);
            if (TIMEOUT_VAL <= WAIT_W'(1)) begin
              state       <= ERROR;
              mem_timeout <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt + WAIT_W'(1) == TIMEOUT_VAL) begin
            // This edge ends wait cycle MEM_TIMEOUT: declare the access hung.
            state       <= ERROR;
            wait_cnt    <= TIMEOUT_VAL;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It watches the IF/ID, ID/EX and MEM stages and drives the hold, flush and bubble controls of the PC and the pipeline registers. It resolves four conditions: load-use data hazards, taken-branch squashes, data-memory wait states, and memory timeout. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 15: consecutive wait cycles after which the memory access is declared hung.
- CNT_W, 16: width of the performance counters.

Ports (name, direction, width, meaning):
- clk, in, 1: the only clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rs1_IF_ID, in, 5: source register 1 of the instruction in ID.
- rs2_IF_ID, in, 5: source register 2 of the instruction in ID.
- uses_rs2_IF_ID, in, 1: the ID instruction really reads rs2 (R-type, store, branch).
- rd_ID_EX, in, 5: destination register of the EX instruction, after the RegDst mux.
- Mem_Read_ID_EX, in, 1: the EX instruction is a load.
- Reg_Write_ID_EX, in, 1: the EX instruction writes the register file.
- branch_taken_EX, in, 1: a branch resolved taken in EX this cycle.
- dmem_req, in, 1: the MEM stage is issuing a data-memory access.
- dmem_ready, in, 1: data memory completes the access this cycle.
- pc_en, out, 1: PC update enable.
- if_id_en, out, 1: IF/ID load enable.
- if_id_flush, out, 1: load a NOP into IF/ID.
- id_ex_en, out, 1: ID/EX load enable.
- id_ex_bubble, out, 1: zero all ID/EX control fields on load.
- ex_mem_en, out, 1: EX/MEM load enable.
- mem_wb_en, out, 1: MEM/WB load enable.
- stall_cnt, out, CNT_W: count of stall cycles.
- flush_cnt, out, CNT_W: count of taken-branch squashes.
- mem_timeout, out, 1: sticky hung-memory flag.

## Operation
FSM states are RUN, MEM_WAIT and ERROR. Reset state is RUN.

Hazard terms:
- mem_stall = dmem_req & !dmem_ready.
- load_use = Mem_Read_ID_EX & Reg_Write_ID_EX & (rd_ID_EX != 0) & ((rd_ID_EX == rs1_IF_ID) | (uses_rs2_IF_ID & (rd_ID_EX == rs2_IF_ID))).

Output decode is combinational from state and inputs. Priority is ERROR > mem_stall > branch > load_use > normal.
- ERROR: all enables 0; flush and bubble 0. The pipeline stays frozen until reset.
- mem_stall, in RUN or MEM_WAIT: all five enables 0. branch_taken_EX and load_use are ignored; they are re-evaluated once the freeze releases.
- Branch, with branch_taken_EX and no mem_stall: all enables 1, if_id_flush=1, id_ex_bubble=1. This squashes both younger instructions. A simultaneous load_use is discarded.
- load_use only: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1, mem_wb_en=1. This inserts exactly one bubble; the next cycle the load has left EX and load_use drops.
- Normal: all enables 1; flush and bubble 0.

Transitions:
- RUN → MEM_WAIT on mem_stall; the wait counter loads 1.
- MEM_WAIT → RUN on dmem_ready. The release cycle decodes as normal/branch/load_use.
- MEM_WAIT, still stalled: the counter increments. When the counter equals MEM_TIMEOUT with dmem_ready still 0, the FSM moves to ERROR and sets mem_timeout=1.
- The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits wide and clears on entering RUN.

Counters:
- stall_cnt increments each cycle pc_en=0 outside ERROR.
- flush_cnt increments each cycle the branch squash is applied.
- Both saturate at all ones and never wrap.

Reset:
- While rst_n=0, every output is 0, including enables and counters, and mem_timeout is cleared.
- Reset asserted mid-MEM_WAIT or in ERROR returns the FSM to RUN immediately.

## Timing
- Hazard outputs have zero-cycle latency: they respond combinationally in the same cycle as the hazard.
- Only the FSM, wait counter, perf counters and mem_timeout are registered.
- mem_timeout asserts on the edge ending wait cycle MEM_TIMEOUT; it is high from the following cycle.
- A load-use stall costs exactly 1 cycle, a taken branch costs 2 squashed slots, and a memory wait of N cycles costs N stall cycles.

## Structure
- Shared package `pipe_pkg`: the FSM state enum and the register-zero constant.
- The wait counter and perf counters are inline; no sub-module is needed.
- The ID/EX, EX/MEM and MEM/WB registers gain an enable input, and ID/EX gains a bubble input, to consume these controls.

## Test plan
- Load-use: lw with rd=5 in EX, ID reads rs1=5. Required: one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle all enables 1; stall_cnt=1.
- No false hazard:
  - rd_ID_EX=0 with a load and rs1=0 → no stall.
  - rs2 matches but uses_rs2_IF_ID=0 → no stall.
- Branch vs load-use: branch_taken_EX=1 together with load_use. Required: if_id_flush=1, id_ex_bubble=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles and a taken branch in EX. Required: all enables 0 for 3 cycles; on the release cycle the flush is applied; stall_cnt=3.
- Timeout: dmem_ready held low for 15 cycles. Required: mem_timeout=1 and the pipeline stays frozen. Then drop rst_n asynchronously mid-cycle: all outputs go to 0 at once and the FSM is in RUN after release.
- Saturation: with CNT_W=4, force 20 stall cycles. Required: stall_cnt holds at 15.
